// File: rtl/wshb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port, ownership held per cycle.
// Define WSHB_ARB_TIMEOUT_EN to add a watchdog that errors and releases a stalled owner.
module wshb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [NUM_MASTERS-1:0]           m_cyc,
    input  logic [NUM_MASTERS-1:0]           m_stb,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0]    m_adr,
    input  logic [NUM_MASTERS*8*DATA_BYTES-1:0] m_dat_ms,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0] m_sel,
    input  logic [NUM_MASTERS*3-1:0]         m_cti,
    input  logic [NUM_MASTERS*2-1:0]         m_bte,
    output logic [NUM_MASTERS-1:0]           m_ack,
    output logic [NUM_MASTERS-1:0]           m_err,
    output logic [NUM_MASTERS-1:0]           m_rty,
    output logic [8*DATA_BYTES-1:0]          m_dat_sm,
    output logic                             s_cyc,
    output logic                             s_stb,
    output logic                             s_we,
    output logic [ADDR_W-1:0]                s_adr,
    output logic [8*DATA_BYTES-1:0]          s_dat_ms,
    output logic [DATA_BYTES-1:0]            s_sel,
    output logic [2:0]                       s_cti,
    output logic [1:0]                       s_bte,
    input  logic                             s_ack,
    input  logic                             s_err,
    input  logic                             s_rty,
    input  logic [8*DATA_BYTES-1:0]          s_dat_sm,
    output logic [NUM_MASTERS-1:0]           grant
);
    localparam int unsigned DataW = 8 * DATA_BYTES;
    localparam int unsigned IdxW  = $clog2(NUM_MASTERS);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy;
    logic                   req_found;
    logic [IdxW-1:0]        req_idx;
    logic [IdxW-1:0]        cand;
    logic                   timeout_hit;

    logic [ADDR_W-1:0] adr_arr [NUM_MASTERS];
    logic [DataW-1:0]  dat_arr [NUM_MASTERS];
    logic [DATA_BYTES-1:0] sel_arr [NUM_MASTERS];
    logic [2:0]        cti_arr [NUM_MASTERS];
    logic [1:0]        bte_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign adr_arr[g] = m_adr[g*ADDR_W +: ADDR_W];
        assign dat_arr[g] = m_dat_ms[g*DataW +: DataW];
        assign sel_arr[g] = m_sel[g*DATA_BYTES +: DATA_BYTES];
        assign cti_arr[g] = m_cti[g*3 +: 3];
        assign bte_arr[g] = m_bte[g*2 +: 2];
    end

    assign busy     = (state_q == StBusy);
    assign grant    = grant_q;
    assign m_dat_sm = s_dat_sm;

    // First requester after the previous owner, wrapping modulo NUM_MASTERS.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
            cand = IdxW'((32'(last_q) + 32'(i)) % NUM_MASTERS);
            if (!req_found && m_cyc[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        if (state_q == StIdle) begin
            if (req_found) begin
                state_d          = StBusy;
                owner_d          = req_idx;
                last_d           = req_idx;
                grant_d          = '0;
                grant_d[req_idx] = 1'b1;
            end
        end else if (!m_cyc[owner_q] || timeout_hit) begin
            state_d = StIdle;
            grant_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_MASTERS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        if (busy && !timeout_hit) begin
            s_cyc    = m_cyc[owner_q];
            s_stb    = m_stb[owner_q];
            s_we     = m_we[owner_q];
            s_adr    = adr_arr[owner_q];
            s_dat_ms = dat_arr[owner_q];
            s_sel    = sel_arr[owner_q];
            s_cti    = cti_arr[owner_q];
            s_bte    = bte_arr[owner_q];
        end
    end

    always_comb begin
        m_ack = '0;
        m_err = '0;
        m_rty = '0;
        if (busy) begin
            m_ack[owner_q] = s_ack;
            m_err[owner_q] = s_err | timeout_hit;
            m_rty[owner_q] = s_rty;
        end
    end

`ifdef WSHB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            stb_raw;
    logic            resp;

    assign stb_raw     = busy & m_cyc[owner_q] & m_stb[owner_q];
    assign resp        = s_ack | s_err | s_rty;
    // Fires on the TIMEOUT_CYCLES-th unanswered strobe cycle.
    assign timeout_hit = stb_raw && !resp && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tmo_cnt_q <= '0;
        end else if (!busy || resp || timeout_hit) begin
            tmo_cnt_q <= '0;
        end else if (stb_raw) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Self-checking bench for wshb_rr_arbiter: directed phases plus randomized masters/slave
// checked cycle by cycle against an ownership model built from the round-robin rules.
module tb_wshb_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DB = 4;
    localparam int DW = 32;

    logic sys_clk = 1'b0;
    logic sys_rst;

    logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_ms;
    logic [N*DB-1:0] m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [DW-1:0]   m_dat_sm, s_dat_ms, s_dat_sm;
    logic            s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [AW-1:0]   s_adr;
    logic [DB-1:0]   s_sel;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;

    logic [3:0]      m4_cyc, grant4, m4_ack, m4_err, m4_rty;
    logic [DW-1:0]   m4_dat_sm, s4_dat_ms;
    logic            s4_cyc, s4_stb, s4_we;
    logic [AW-1:0]   s4_adr;
    logic [DB-1:0]   s4_sel;
    logic [2:0]      s4_cti;
    logic [1:0]      s4_bte;

    wshb_rr_arbiter #(.NUM_MASTERS(N)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_ms(m_dat_ms),
        .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
        .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .grant(grant)
    );

    wshb_rr_arbiter #(.NUM_MASTERS(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_cyc(m4_cyc), .m_stb(4'b0), .m_we(4'b0), .m_adr('0), .m_dat_ms('0),
        .m_sel('0), .m_cti('0), .m_bte('0),
        .m_ack(m4_ack), .m_err(m4_err), .m_rty(m4_rty), .m_dat_sm(m4_dat_sm),
        .s_cyc(s4_cyc), .s_stb(s4_stb), .s_we(s4_we), .s_adr(s4_adr), .s_dat_ms(s4_dat_ms),
        .s_sel(s4_sel), .s_cti(s4_cti), .s_bte(s4_bte),
        .s_ack(1'b0), .s_err(1'b0), .s_rty(1'b0), .s_dat_sm('0),
        .grant(grant4)
    );

    always #5 sys_clk = ~sys_clk;

    // Master programs and reference model state.
    int          rem [N];
    int          beat [N];
    int          gap [N];
    logic [31:0] base [N];
    logic        we_t [N];
    logic [3:0]  sel_t [N];
    logic [1:0]  bte_t [N];
    int          owner, last, owner4, last4;
    int          wcnt, wait_tgt, fixed_wait, fixed_len;
    bit          auto_en, rec_en, burst_watch;
    int          obs_ack [N];
    int          ack0_at_g1;
    logic [1:0]  gq [$];
    logic [1:0]  exp_seq [5];
    int          n_checks, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int lst, input logic [7:0] req, input int n);
        int c;
        for (int k = 1; k <= n; k++) begin
            c = (lst + k) % n;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] dat_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        owner = -1; last = N - 1; owner4 = -1; last4 = 3; wcnt = 0;
    endtask

    task automatic set_wait(input int w);
        fixed_wait = w;
        wait_tgt   = (w >= 0) ? w : int'($urandom_range(3, 0));
    endtask

    task automatic start_txn(input int i, input int len);
        rem[i]   = len;
        beat[i]  = 0;
        base[i]  = $urandom & 32'h000F_FFF0;
        we_t[i]  = 1'($urandom);
        sel_t[i] = 4'($urandom);
        bte_t[i] = 2'($urandom);
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
                m_we[i]  = we_t[i];
                m_adr[i*AW +: AW]    = base[i] + (32'(beat[i]) << 2);
                m_dat_ms[i*DW +: DW] = 32'hC0DE_0000 | (32'(i) << 8) | 32'(beat[i]);
                m_sel[i*DB +: DB]    = sel_t[i];
                m_cti[i*3 +: 3]      = (rem[i] == 1) ? 3'b111 : 3'b010;
                m_bte[i*2 +: 2]      = bte_t[i];
            end else begin
                m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
                m_adr[i*AW +: AW] = '0; m_dat_ms[i*DW +: DW] = '0;
                m_sel[i*DB +: DB] = '0; m_cti[i*3 +: 3] = '0; m_bte[i*2 +: 2] = '0;
            end
        end
    endtask

    // One clock cycle of the two-master system: drive, respond, check, then advance the model.
    task automatic tick();
        logic [N-1:0]  cyc_now, e_ack, e_err, e_rty, e_grant;
        logic [43:0]   e_bus;
        logic [DW-1:0] e_dms;
        bit            xfer;
        int            resp, o, r;
        drive_masters();
        cyc_now = m_cyc;
        o = owner;
        xfer = 1'b0;
        if (sys_rst && o >= 0) xfer = (rem[o] > 0);
        resp = 0;
        if (xfer && wcnt >= wait_tgt) begin
            resp = 1;
            if (fixed_wait < 0) begin
                r = int'($urandom_range(7, 0));
                if (r == 0) resp = 2;
                else if (r == 1) resp = 3;
            end
        end
        s_ack = (resp == 1);
        s_err = (resp == 2);
        s_rty = (resp == 3);
        e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_bus = '0; e_dms = '0;
        if (o >= 0) begin
            s_dat_sm   = dat_of(m_adr[o*AW +: AW]);
            e_grant[o] = 1'b1;
            e_ack[o]   = (resp == 1);
            e_err[o]   = (resp == 2);
            e_rty[o]   = (resp == 3);
            e_bus = {m_cyc[o], m_stb[o], m_we[o], m_adr[o*AW +: AW], m_sel[o*DB +: DB],
                     m_cti[o*3 +: 3], m_bte[o*2 +: 2]};
            e_dms = m_dat_ms[o*DW +: DW];
        end else begin
            s_dat_sm = $urandom;
        end
        #1;
        chk("grant", grant, e_grant);
        chk("slave_bus", {s_cyc, s_stb, s_we, s_adr, s_sel, s_cti, s_bte}, e_bus);
        chk("s_dat_ms", s_dat_ms, e_dms);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_rty", m_rty, e_rty);
        chk("m_dat_sm", m_dat_sm, s_dat_sm);
        for (int i = 0; i < N; i++) obs_ack[i] += int'(m_ack[i]);
        if (rec_en && (gq.size() == 0 || gq[$] != grant)) gq.push_back(grant);
        if (burst_watch && grant[1] === 1'b1 && ack0_at_g1 < 0) ack0_at_g1 = obs_ack[0];
        @(posedge sys_clk);
        if (sys_rst) begin
            if (auto_en) begin
                for (int i = 0; i < N; i++) begin
                    if (rem[i] == 0) begin
                        if (gap[i] > 0) gap[i]--;
                        if (gap[i] == 0)
                            start_txn(i, (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1)));
                    end
                end
            end
            if (resp != 0) begin
                rem[o]--;
                beat[o]++;
                wcnt = 0;
                wait_tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3, 0));
                if (rem[o] == 0) gap[o] = (fixed_len > 0) ? 1 : int'($urandom_range(3, 1));
            end else if (xfer) begin
                wcnt++;
            end
            if (o >= 0) begin
                if (!cyc_now[o]) owner = -1;
            end else if (cyc_now != '0) begin
                owner = rr_pick(last, 8'(cyc_now), N);
                last  = owner;
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic tick4(input logic [3:0] req);
        logic [3:0] e;
        m4_cyc = req;
        #1;
        e = '0;
        if (owner4 >= 0) e[owner4] = 1'b1;
        chk("grant4", grant4, e);
        @(posedge sys_clk);
        if (owner4 >= 0) begin
            if (!req[owner4]) owner4 = -1;
        end else if (req != 4'b0) begin
            owner4 = rr_pick(last4, {4'b0, req}, 4);
            last4  = owner4;
        end
        @(negedge sys_clk);
    endtask

    task automatic run_until_idle(input string tag, input int bound);
        int k;
        k = 0;
        while ((rem[0] > 0 || rem[1] > 0 || owner >= 0) && k < bound) begin
            tick();
            k++;
        end
        chk(tag, k < bound, 1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_ms = '0;
        m_sel = '0; m_cti = '0; m_bte = '0; m4_cyc = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = '0;
        rec_en = 0; burst_watch = 0; ack0_at_g1 = -1;
        for (int i = 0; i < N; i++) begin gap[i] = 0; obs_ack[i] = 0; end

        // Reset held with both masters requesting, then continuous contention of 3 transfers.
        sys_rst = 1'b0;
        model_reset();
        set_wait(-1);
        auto_en = 1; fixed_len = 3;
        start_txn(0, 3);
        start_txn(1, 3);
        #1;
        chk("reset_grant_async", grant, 2'b00);
        @(negedge sys_clk);
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        rec_en = 1;
        repeat (60) tick();
        rec_en = 0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b00; exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b00; exp_seq[4] = 2'b01;
        chk("contention_seq_len", gq.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            if (k < gq.size()) chk($sformatf("contention_seq%0d", k), gq[k], exp_seq[k]);

        // Randomized traffic: random lengths, gaps, wait states and err/rty responses.
        fixed_len = 0;
        repeat (400) tick();

        // Asynchronous reset in the middle of traffic.
        sys_rst = 1'b0;
        auto_en = 0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        model_reset();
        tick();
        tick();
        sys_rst = 1'b1;
        tick();

        // Single master: four reads from 0x100 with two wait states each.
        set_wait(2);
        for (int i = 0; i < N; i++) obs_ack[i] = 0;
        start_txn(1, 4);
        base[1] = 32'h100;
        we_t[1] = 1'b0;
        run_until_idle("single_done", 100);
        chk("single_ack1", obs_ack[1], 4);
        chk("single_ack0", obs_ack[0], 0);

        // Burst integrity: master1 waits for master0's whole 8-beat burst.
        set_wait(1);
        for (int i = 0; i < N; i++) obs_ack[i] = 0;
        burst_watch = 1;
        start_txn(0, 8);
        tick();
        tick();
        start_txn(1, 2);
        run_until_idle("burst_done", 200);
        burst_watch = 0;
        chk("burst_m1_after_beat8", ack0_at_g1, 8);
        chk("burst_ack1", obs_ack[1], 2);

`ifndef WSHB_ARB_TIMEOUT_EN
        // Without the watchdog an unanswered owner keeps the bus.
        start_txn(0, 1);
        set_wait(1000000);
        repeat (300) tick();
        chk("hold_grant", grant, 2'b01);
        chk("hold_stb", s_stb, 1'b1);
        set_wait(0);
        run_until_idle("hold_release", 20);
`endif

        // Four-master instance: wrap from last=3, then random request patterns.
        tick4(4'b1001);
        tick4(4'b1000);
        tick4(4'b1000);
        tick4(4'b0000);
        tick4(4'b0000);
        repeat (80) tick4(4'($urandom));
        tick4(4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
